hps_image_loader: RTL
=====================

Name: hps_image_loader

Overview:
- HPS-facing command front end: the initiator side of the image-processing controller handshake.
- Accepts 32-bit command words from HPS PIO registers over a 4-phase valid/ack handshake.
- Writes pixels into the image RAM while asserting hps_writing_image, and issues the single-cycle start pulse.
- Tracks the processor's done (busy, done, timeout) and exposes sticky status flags back to the HPS.

Parameters:
- ADDR_W, 17, image RAM address width.
- DATA_W, 8, pixel width.
- IMG_PIXELS, 76800, number of valid pixel addresses (0..IMG_PIXELS-1).
- TIMEOUT_CYC, 50000000, maximum cycles to wait for done after start.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_data  in  32  command word: [31:28] opcode, [24:8] address, [7:0] pixel.
- cmd_valid  in  1  level; HPS holds it high until cmd_ack, then drops it.
- cmd_ack  out  1  command completed; held high until cmd_valid low.
- mem_addr  out  ADDR_W  image RAM write address.
- mem_wdata  out  DATA_W  image RAM write data.
- mem_wren  out  1  image RAM write strobe.
- hps_writing_image  out  1  high exactly when mem_wren is high.
- start  out  1  single-cycle pulse to the controller.
- proc_done  in  1  processor-finished pulse.
- status  out  4  {err_timeout, err_cmd, done_flag, busy}.

Behaviour:
- Reset: state IDLE, command register 0, counter 0; all outputs 0, including status.
- Clocking: clk and cmd_data/cmd_valid share one clock domain, so there is no synchronizer. Outputs are decoded from registered state and registers.
- Opcodes: 0 NOP, 1 WRITE_PIXEL, 2 START, 3 CLEAR_STATUS. Any other value is illegal.
- IDLE:
  - cmd_valid=1 at edge k: latch cmd_data; DECODE after edge k.
- DECODE (one cycle):
  - WRITE_PIXEL, !busy, addr<IMG_PIXELS -> WRITE.
  - WRITE_PIXEL with busy, or addr>=IMG_PIXELS -> set err_cmd -> ACK. No RAM write.
  - START, !busy -> STRT.
  - START with busy -> set err_cmd -> ACK.
  - CLEAR_STATUS -> clear done_flag, err_cmd, err_timeout -> ACK. busy is untouched.
  - NOP -> ACK.
  - Illegal opcode -> set err_cmd -> ACK.
- WRITE (one cycle):
  - mem_wren=1 and hps_writing_image=1.
  - mem_addr = cmd[24:8] truncated to ADDR_W; mem_wdata = cmd[7:0].
  - Then ACK.
- STRT (one cycle):
  - start=1; set busy; clear done_flag; timeout counter := 0.
  - Then ACK.
- ACK:
  - cmd_ack=1 while cmd_valid=1.
  - When cmd_valid=0 is sampled: IDLE, cmd_ack=0 next cycle.
  - A command whose cmd_valid is still high is never re-executed.
- Latency: for a WRITE_PIXEL first sampled at edge k:
  - mem_wren is high during cycle k+1..k+2 (state WRITE).
  - cmd_ack rises after edge k+2.
  - START is analogous, with start in the same slot.
- mem_addr and mem_wdata hold their last values when mem_wren=0.
- Busy tracker (parallel to the FSM):
  - While busy, the counter increments each cycle.
  - proc_done=1 while busy: busy:=0, done_flag:=1.
  - Counter reaches TIMEOUT_CYC-1 while busy: busy:=0, err_timeout:=1.
  - proc_done on the same cycle as the timeout: done wins; err_timeout is not set.
  - proc_done while !busy is ignored.
  - proc_done on the same edge as STRT's start pulse is ignored; busy becomes 1.
- Flags:
  - done_flag, err_cmd and err_timeout are sticky until CLEAR_STATUS or reset.
  - CLEAR on the same edge as a set: set wins.
- Reset mid-operation: immediate return to reset values. Any in-flight write strobe, start or busy state is dropped. The HPS must reissue the command after reset.

Test Plan:
- Write pixel:
  - Stimulus: cmd 0x1_0_01234_A5 (opcode 1, addr 0x1234, data 0xA5), then cmd_valid low after ack.
  - Required: exactly one cycle of mem_wren=hps_writing_image=1 with mem_addr=0x1234, mem_wdata=0xA5, two cycles after cmd_valid is first sampled. cmd_ack high until cmd_valid drops. status=0.
- Start/done:
  - Stimulus: START; proc_done pulse 100 cycles later.
  - Required: one start pulse; status=0001 until done; then status=0010.
- Busy guard:
  - Stimulus: START, then WRITE_PIXEL addr 5 before done.
  - Required: no mem_wren; status err_cmd=1 (0101).
  - Stimulus (continued): CLEAR_STATUS.
  - Required: status=0001.
- Range/opcode:
  - Stimulus: WRITE_PIXEL addr 76800, then opcode 0xF.
  - Required: no write and err_cmd=1 in each case; cmd_ack still completes the handshake.
- Timeout: TIMEOUT_CYC=16.
  - Stimulus: START with no done.
  - Required: busy clears and err_timeout=1 after 16 cycles.
  - Stimulus: repeat with proc_done on exactly the timeout cycle.
  - Required: done_flag=1, err_timeout=0.
- Reset mid-operation:
  - Stimulus: assert reset during the WRITE state, and again while busy.
  - Required: all outputs 0 immediately; the next command executes normally.

Source files
------------

// File: rtl/hps_image_loader.sv
// hps_image_loader
//   HPS-facing command front end for the image-processing controller.
//   Command words arrive from HPS PIO registers over a 4-phase valid/ack
//   handshake. Each command either writes one pixel into the image RAM,
//   kicks the processor with a single-cycle start pulse, clears the sticky
//   status flags, or does nothing. A busy tracker runs alongside the command
//   FSM, watching for proc_done or a timeout after each start.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   cmd_data[31:0]      command: [31:28] opcode, [24:8] address, [7:0] pixel
//   cmd_valid           level from HPS, held until cmd_ack is seen
//   cmd_ack             command finished, held while cmd_valid stays high
//   mem_addr/mem_wdata  image RAM write address/data (hold when idle)
//   mem_wren            image RAM write strobe
//   hps_writing_image   mirrors mem_wren for the controller's RAM arbiter
//   start               single-cycle pulse to the processor
//   proc_done           processor-finished pulse
//   status[3:0]         {err_timeout, err_cmd, done_flag, busy}

module hps_image_loader #(
  parameter int ADDR_W      = 17,
  parameter int DATA_W      = 8,
  parameter int IMG_PIXELS  = 76800,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       cmd_data,
  input  logic              cmd_valid,
  output logic              cmd_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              hps_writing_image,
  output logic              start,
  input  logic              proc_done,
  output logic [3:0]        status
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_START = 4'd2;
  localparam logic [3:0] OP_CLEAR = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WRITE,
    S_STRT,
    S_ACK
  } state_t;

  state_t state, state_next;

  logic [3:0]       cmd_op;
  logic [16:0]      cmd_addr;
  logic [7:0]       cmd_pix;
  logic             addr_ok;

  logic             busy;
  logic             done_flag;
  logic             err_cmd;
  logic             err_timeout;
  logic [CNT_W-1:0] counter;

  logic             cmd_err_set;
  logic             clear_status;
  logic             load_write;

  // Bits 27:25 of the command word carry no meaning.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^cmd_data[27:25];

  // The address field is range-checked at its full 17-bit width, before any
  // truncation to the RAM address width.
  assign addr_ok = {15'd0, cmd_addr} < 32'(IMG_PIXELS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and output decode. Every output is a function of the
  // registered state only, so none of them glitch with cmd_valid.
  always_comb begin
    state_next        = state;
    cmd_err_set       = 1'b0;
    clear_status      = 1'b0;
    load_write        = 1'b0;
    cmd_ack           = 1'b0;
    mem_wren          = 1'b0;
    hps_writing_image = 1'b0;
    start             = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) state_next = S_DECODE;
      end
      S_DECODE: begin
        case (cmd_op)
          OP_WRITE: begin
            if (!busy && addr_ok) begin
              load_write = 1'b1;
              state_next = S_WRITE;
            end else begin
              cmd_err_set = 1'b1;
              state_next  = S_ACK;
            end
          end
          OP_START: begin
            if (!busy) begin
              state_next = S_STRT;
            end else begin
              cmd_err_set = 1'b1;
              state_next  = S_ACK;
            end
          end
          OP_CLEAR: begin
            clear_status = 1'b1;
            state_next   = S_ACK;
          end
          OP_NOP: begin
            state_next = S_ACK;
          end
          default: begin
            cmd_err_set = 1'b1;
            state_next  = S_ACK;
          end
        endcase
      end
      S_WRITE: begin
        mem_wren          = 1'b1;
        hps_writing_image = 1'b1;
        state_next        = S_ACK;
      end
      S_STRT: begin
        start      = 1'b1;
        state_next = S_ACK;
      end
      S_ACK: begin
        cmd_ack = 1'b1;
        // Only return to IDLE once the HPS has dropped valid, so a word that
        // is still presented is never executed twice.
        if (!cmd_valid) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Command register, loaded only in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_op   <= 4'd0;
      cmd_addr <= 17'd0;
      cmd_pix  <= 8'd0;
    end else if (state == S_IDLE && cmd_valid) begin
      cmd_op   <= cmd_data[31:28];
      cmd_addr <= cmd_data[24:8];
      cmd_pix  <= cmd_data[7:0];
    end
  end

  // RAM address/data are registered so they hold their last values between
  // writes instead of following whatever command is latched next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (load_write) begin
      mem_addr  <= ADDR_W'(cmd_addr);
      mem_wdata <= DATA_W'(cmd_pix);
    end
  end

  // Busy tracker and sticky flags. Clearing is applied first so that a flag
  // set on the same edge survives. The start pulse takes priority over
  // proc_done, so a done arriving with the pulse is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done_flag   <= 1'b0;
      err_cmd     <= 1'b0;
      err_timeout <= 1'b0;
      counter     <= '0;
    end else begin
      if (clear_status) begin
        done_flag   <= 1'b0;
        err_cmd     <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (cmd_err_set) err_cmd <= 1'b1;
      if (state == S_STRT) begin
        busy      <= 1'b1;
        done_flag <= 1'b0;
        counter   <= '0;
      end else if (busy) begin
        if (proc_done) begin
          busy      <= 1'b0;
          done_flag <= 1'b1;
        end else if (counter == CNT_W'(TIMEOUT_CYC - 1)) begin
          busy        <= 1'b0;
          err_timeout <= 1'b1;
        end else begin
          counter <= counter + CNT_W'(1);
        end
      end
    end
  end

  assign status = {err_timeout, err_cmd, done_flag, busy};

endmodule
